// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT stream constants, FSM encoding and helpers
package fft_pkg;
  localparam int FFT_LEN  = 1024;
  localparam int ADDR_W   = $clog2(FFT_LEN);
  localparam int NUM_BINS = 512;
  localparam int BIN_W    = $clog2(NUM_BINS);
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    stIdle = 3'b001,
    stFill = 3'b010,
    stSwap = 3'b100
  } state_e;

  function automatic logic [BYTE_W-1:0] sat_sub(input logic [BYTE_W-1:0] a,
                                                input logic [BYTE_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction
endpackage

// File: rtl/freq_dp_bank.sv
// rtl/freq_dp_bank.sv - two-bank simple dual-port RAM, bank on address MSB
module freq_dp_bank #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/freq_frame_buffer.sv
// rtl/freq_frame_buffer.sv - ping-pong FFT frame capture with decaying peak hold
module freq_frame_buffer #(
  parameter int         NUM_BINS   = fft_pkg::NUM_BINS,
  parameter int         BIN_W      = fft_pkg::BIN_W,
  parameter logic [7:0] PEAK_DECAY = 8'd2
) (
  input  logic                      ckFreq,
  input  logic                      aresetn,
  input  logic                      flgFreqSampleValid,
  input  logic [fft_pkg::ADDR_W-1:0] addrFreq,
  input  logic [7:0]                byteFreqSample,
  input  logic                      flgFreeze,
  input  logic                      rdEn,
  input  logic [BIN_W-1:0]          rdAddr,
  output logic [7:0]                rdData,
  output logic [7:0]                rdPeak,
  output logic                      flgFrameDone,
  output logic                      flgFrameErr,
  output logic [15:0]               cntFrames
);
  import fft_pkg::*;

  localparam logic [ADDR_W:0]   BINS_EXT = (ADDR_W+1)'(NUM_BINS);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS-1);

  state_e           state, state_next;
  logic             sel_bank;
  logic [BIN_W-1:0] expected, expected_next;
  logic             wr_en, do_swap, err_set;
  logic             in_range, addr_zero, addr_last;
  logic [BIN_W-1:0] wr_bin;
  logic             wr_bank;

  assign in_range  = ({1'b0, addrFreq} < BINS_EXT);
  assign addr_zero = (addrFreq == '0);
  assign addr_last = (addrFreq == LAST_BIN);
  assign wr_bin    = addrFreq[BIN_W-1:0];

  always_comb begin
    state_next    = state;
    expected_next = expected;
    wr_en         = 1'b0;
    do_swap       = 1'b0;
    err_set       = 1'b0;
    case (state)
      stIdle, stSwap: begin
        if (state == stSwap) begin
          do_swap    = !flgFreeze;
          state_next = stIdle;
        end
        if (flgFreqSampleValid && addr_zero) begin
          wr_en         = 1'b1;
          expected_next = BIN_W'(1);
          state_next    = stFill;
        end
      end
      stFill: begin
        if (flgFreqSampleValid && in_range) begin
          if (wr_bin == expected) begin
            wr_en         = 1'b1;
            expected_next = expected + 1'b1;
            if (addr_last) state_next = stSwap;
          end else begin
            err_set = 1'b1;
            if (addr_zero) begin
              wr_en         = 1'b1;
              expected_next = BIN_W'(1);
            end else begin
              state_next = stIdle;
            end
          end
        end
      end
      default: state_next = stIdle;
    endcase
  end

  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn) begin
      state        <= stIdle;
      sel_bank     <= 1'b0;
      expected     <= '0;
      flgFrameDone <= 1'b0;
      flgFrameErr  <= 1'b0;
      cntFrames    <= '0;
    end else begin
      state        <= state_next;
      expected     <= expected_next;
      flgFrameDone <= do_swap;
      flgFrameErr  <= err_set;
      if (do_swap) begin
        sel_bank  <= ~sel_bank;
        cntFrames <= cntFrames + 16'd1;
      end
    end
  end

  // A bin-0 write landing in the swap cycle belongs to the bank that becomes writable.
  assign wr_bank = do_swap ? sel_bank : ~sel_bank;

  freq_dp_bank #(
    .ADDR_W(BIN_W + 1),
    .DATA_W(BYTE_W)
  ) u_bank (
    .clk    (ckFreq),
    .rst_n  (aresetn),
    .wr_en  (wr_en),
    .wr_addr({wr_bank, wr_bin}),
    .wr_data(byteFreqSample),
    .rd_en  (rdEn),
    .rd_addr({sel_bank, rdAddr}),
    .rd_data(rdData)
  );

  logic [7:0]          peak_mem [NUM_BINS];
  logic [NUM_BINS-1:0] pending;
  logic [7:0]          peak_cur, peak_dec, peak_new;

  // Decay is deferred to the next write of each bin; a swap in this cycle counts.
  assign peak_cur = peak_mem[wr_bin];
  assign peak_dec = (pending[wr_bin] || do_swap) ? sat_sub(peak_cur, PEAK_DECAY) : peak_cur;
  assign peak_new = (byteFreqSample > peak_dec) ? byteFreqSample : peak_dec;

  always_ff @(posedge ckFreq) begin
    if (do_swap) pending <= '1;
    if (wr_en) begin
      pending[wr_bin]  <= 1'b0;
      peak_mem[wr_bin] <= peak_new;
    end
  end

  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn)  rdPeak <= '0;
    else if (rdEn) rdPeak <= peak_mem[rdAddr];
  end
endmodule

// File: doc/freq_frame_buffer.md
Name: freq_frame_buffer

Overview:
- Consumer end of the FFT frequency-sample stream (flgFreqSampleValid / addrFreq / byteFreqSample).
- Captures bins 0..NUM_BINS-1 of each FFT frame into a ping-pong buffer and swaps banks only on a complete, contiguous frame.
- Serves a 1-cycle-latency read port to the bar-display logic, returning both the current magnitude and a per-bin decaying peak-hold value.

Parameters:
- NUM_BINS, 512: bins stored per frame (power of 2, ≤1024).
- BIN_W, 9: log2(NUM_BINS).
- PEAK_DECAY, 8'd2: amount subtracted from each bin's peak per completed frame.

Ports:
- ckFreq  in  1  clock; same domain as the FFT output registers.
- aresetn  in  1  asynchronous reset, active low.
- flgFreqSampleValid  in  1  frequency sample valid.
- addrFreq  in  10  FFT bin index of the current sample.
- byteFreqSample  in  8  magnitude of the current sample.
- flgFreeze  in  1  when 1, bank swaps are inhibited; the display stays static.
- rdEn  in  1  display read strobe.
- rdAddr  in  BIN_W  display bin index.
- rdData  out  8  magnitude of bin rdAddr from the display bank.
- rdPeak  out  8  peak-hold value of bin rdAddr.
- flgFrameDone  out  1  one-cycle pulse when a bank swap occurs.
- flgFrameErr  out  1  one-cycle pulse when a frame is aborted.
- cntFrames  out  16  count of swapped frames; wraps at 0xFFFF→0.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State stIdle; selBank=0; expected address cleared.
  - rdData, rdPeak, flgFrameDone, flgFrameErr and cntFrames are all 0.
  - Peak memory is not cleared by reset.
- Reset mid-frame: the partial frame is discarded; the display bank is unchanged but reads return 0 until the first rdEn after release.
- Write bank = !selBank; display bank = selBank.
- FSM states: stIdle, stFill, stSwap.
- stIdle:
  - On valid with addrFreq==0: write byte to write bank [0], set expected=1, go to stFill.
  - Valid with any other address is ignored.
- stFill, each valid sample:
  - If addrFreq==expected and < NUM_BINS: write it and increment expected.
  - If addrFreq==NUM_BINS-1 is written: go to stSwap.
  - If addrFreq != expected: pulse flgFrameErr the next cycle and go to stIdle. If that sample's addrFreq==0, re-enter stFill directly with it written (restart, no lost frame).
  - Valid low in stFill: hold state; gaps are legal.
- stSwap (one cycle):
  - If flgFreeze==0: toggle selBank, pulse flgFrameDone, increment cntFrames, apply decay to every peak (see peak rule).
  - If flgFreeze==1: no toggle, no pulse, no count; the completed frame is discarded.
  - Always return to stIdle.
  - A valid sample arriving in stSwap is handled per the stIdle rules the same cycle (addr 0 starts the next frame), so back-to-back frames are never lost.
- Bins ≥ NUM_BINS (upper FFT half) never write and never cause an error.
- Peak rule, applied at write time for bin b:
  - peakNew = max(byteFreqSample, peakDecayed[b]).
  - peakDecayed = sat0(peak - PEAK_DECAY × pendingDecay), where pendingDecay is a 1-bit per-bin flag set at each swap and cleared when the bin is written.
  - Saturating subtract: never below 0. Peak memory is single-bank and distributed RAM, read asynchronously.
- Read port:
  - rdEn at cycle N → rdData/rdPeak valid at N+1 and held until the next rdEn.
  - rdPeak returns the stored peak (decay is not applied on read).
  - Read and write are to different banks, so there is no collision. A read in the same cycle as a swap returns the old display bank.

Decomposition:
- Shared package fft_pkg holds FFT_LEN=1024, NUM_BINS, the byte width and the state encodings (one-hot, 3 bits).
- One sub-module, freq_dp_bank: a 2×NUM_BINS×8 simple dual-port RAM with sync write and sync read, bank select on the MSB of the address.
- The FSM, peak logic and counters live at top level.

Test Plan:
- Stream addr 0..1023 with valid=1 and byte=addr[7:0] → flgFrameDone 1 cycle after addr 511 is written; cntFrames=1; reading rdAddr=5 gives rdData=5 one cycle later.
- Two frames back-to-back (second frame has byte=0xFF) → two flgFrameDone pulses, cntFrames=2, rdData=0xFF for all bins, no flgFrameErr.
- Skip addr 100 mid-frame → flgFrameErr pulses once, no swap, display bank still holds the previous frame's data.
- Frame A bin 7=200, then frames with bin 7=0 → rdPeak[7] reads 200, then 198, then 196; it never underflows below 0 with PEAK_DECAY=2.
- flgFreeze=1 during a complete frame → no flgFrameDone, cntFrames unchanged, rdData unchanged. Release freeze, send the next frame → swap occurs normally.
- Assert aresetn=0 at addr 300 → outputs return to 0 asynchronously; after release, the next full frame swaps and cntFrames=1.
